mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Memory-side responder for the accelerator's single-port memory interface (mem_addr/mem_read/mem_write/
//  mem_write_data out; mem_read_data/mem_valid back). Holds a word-wide SRAM array, services writes in one
//  cycle and reads with fixed latency, returns read data in order, and applies backpressure via mem_ready.
//  Sits between amadeus_top and the system memory / testbench as the far end of the controller's memory port.
// PARAMETERS
//  DATA_W        `MEM_BANDWIDTH*8   width of one memory word / data bus
//  ADDR_W        `MEM_ADDR_SIZE     byte-address width
//  DEPTH_WORDS   4096               words in the array; word index = mem_addr >> log2(`MEM_BANDWIDTH)
//  READ_LATENCY  4                  accept-to-mem_valid cycles when unstalled; legal range 2..8
//  QUEUE_DEPTH   8                  max reads in flight (pipeline + response FIFO); power of 2
// PORTS
//  clk             in   1       clock
//  rst             in   1       synchronous reset, active-high
//  mem_addr        in   ADDR_W  byte address of request
//  mem_write_data  in   DATA_W  write data
//  mem_read        in   1       read request, one request per cycle while high
//  mem_write       in   1       write request, one request per cycle while high
//  mem_ready       out  1       request accepted this cycle if high
//  mem_read_data   out  DATA_W  read response data, valid with mem_valid
//  mem_valid       out  1       one-cycle pulse per returned read word
//  stall_in        in   1       holds the response head; mem_valid forced low while high
//  outstanding     out  4       reads accepted but not yet returned (0..QUEUE_DEPTH)
//  error           out  1       sticky protocol/address error
// BEHAVIOUR
//  - Reset (rst high at edge): mem_valid=0, mem_read_data=0, mem_ready=0 during reset, 1 on first cycle after;
//    outstanding=0, error=0; latency pipeline and FIFO flushed, in-flight reads discarded; array contents kept.
//  - Accept: request taken at a rising edge when (mem_read|mem_write) && mem_ready. No accept while mem_ready=0;
//    requester holds the request until accepted.
//  - mem_ready = (outstanding < QUEUE_DEPTH); overflow of the response FIFO is therefore impossible.
//  - Write: array[idx] <= mem_write_data at the accept edge; a read accepted on the next cycle returns new data.
//  - Read: array read at accept; data travels a READ_LATENCY-1 stage valid/data shift pipeline into the response
//    FIFO. With FIFO empty and stall_in=0, read accepted at edge T gives mem_valid=1 in cycle T+READ_LATENCY.
//  - Back-to-back reads: one mem_valid per cycle, strictly in acceptance order, no bubbles when unstalled.
//  - stall_in=1: mem_valid=0, head stays; pipeline keeps draining into FIFO; mem_ready drops when full.
//    mem_read_data holds last returned value whenever mem_valid=0.
//  - outstanding: +1 on accepted read, -1 on mem_valid; both same cycle -> unchanged.
//  - mem_read && mem_write both high: violation -> error<=1, write performed, read dropped (no response).
//  - Misaligned address (low log2(`MEM_BANDWIDTH) bits nonzero) or idx >= DEPTH_WORDS: error<=1; write dropped;
//    read still returns one response with data = 0 to keep ordering.
//  - error clears only on rst. Reset mid-burst: all pending responses lost, no mem_valid after reset
//    until a new read is accepted.
// STRUCTURE
//  - Shared package: typedef MEM_REQ_PACKET {addr, wdata, rd, wr} and MEM_RESP_PACKET {rdata, valid};
//    `MEM_BANDWIDTH/`MEM_ADDR_SIZE stay in the common defines file.
//  - Sub-module mem_resp_fifo: QUEUE_DEPTH x DATA_W sync FIFO, push/pop/full/empty/count, same-cycle push+pop.
//  - Top of block: address decode/check, SRAM array, latency shift register, outstanding counter, error flag.
// TESTING
//  1 Write 0xA5.. to addr 0x40, read 0x40 next cycle -> mem_valid exactly 4 cycles after read accept, data 0xA5..
//  2 8 back-to-back reads addr 0,64..448 preloaded k -> 8 consecutive mem_valid pulses, data 0..7 in order.
//  3 stall_in high 20 cycles during 12-read burst -> mem_ready low after 8 accepts, outstanding=8, no loss,
//    all 12 returned in order after release.
//  4 mem_read&mem_write together at 0x80 with data 0x3C -> error=1, array[2]=0x3C, no mem_valid, outstanding 0.
//  5 Read addr 0x41 (misaligned) and idx=DEPTH_WORDS -> error=1, two responses with data 0, order preserved.
//  6 rst asserted with 3 reads in flight -> mem_valid stays 0, outstanding=0, prior written data readable after.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and sizing for the memory responder block.
//   MEM_BANDWIDTH  bytes per memory word
//   MEM_ADDR_SIZE  byte-address width
//   MEM_REQ_PACKET  request payload {addr, wdata, rd, wr}
//   MEM_RESP_PACKET response payload {rdata, valid}
package mem_responder_pkg;

    localparam int unsigned MEM_BANDWIDTH = 64;
    localparam int unsigned MEM_ADDR_SIZE = 32;

    localparam int unsigned DATA_W = MEM_BANDWIDTH * 8;
    localparam int unsigned ADDR_W = MEM_ADDR_SIZE;
    localparam int unsigned OFFS_W = $clog2(MEM_BANDWIDTH);
    localparam int unsigned OUT_W  = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              rd;
        logic              wr;
    } MEM_REQ_PACKET;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              valid;
    } MEM_RESP_PACKET;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the memory controller and the memory responder.
//   master: drives mem_addr, mem_write_data, mem_read, mem_write; sees mem_ready, mem_read_data, mem_valid
//   slave : the responder side of the same signals
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_read;
    logic              mem_write;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_read_data;
    logic              mem_valid;

    modport master (
        output mem_addr, mem_write_data, mem_read, mem_write,
        input  mem_ready, mem_read_data, mem_valid
    );

    modport slave (
        input  mem_addr, mem_write_data, mem_read, mem_write,
        output mem_ready, mem_read_data, mem_valid
    );

endinterface

// File: rtl/mem_resp_fifo.sv
// Synchronous response FIFO; push and pop may happen in the same cycle.
//   clk, rst   clock, synchronous active-high reset
//   push_i     write din_i (ignored when full unless popping the same cycle)
//   pop_i      drop head (ignored when empty)
//   din_i      write data
//   dout_o     head entry, valid while empty_o is low
//   full_o     FIFO holds DEPTH entries
//   empty_o    FIFO holds no entries
//   count_o    number of entries held
module mem_resp_fifo #(
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned W     = 32,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     din_i,
    output logic [W-1:0]     dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [W-1:0]     store_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push_c;
    logic             do_pop_c;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign count_o   = count_q;
    assign dout_o    = store_q[rd_ptr_q];
    assign do_pop_c  = pop_i & ~empty_o;
    assign do_push_c = push_i & (~full_o | do_pop_c);

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c) store_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/mem_responder.sv
// Far-end memory responder: word SRAM, single-cycle writes, fixed-latency in-order reads,
// backpressure through mem_ready, sticky error flag for protocol/address violations.
//   clk, rst     clock, synchronous active-high reset (array contents survive reset)
//   bus          slave side of mem_responder_if (request in, mem_ready/response out)
//   stall_in     holds the response head; no mem_valid issued while high
//   outstanding  reads accepted but not yet returned
//   error        sticky; set on read+write together, misaligned or out-of-range address
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS  = 4096,
    parameter int unsigned READ_LATENCY = 4,
    parameter int unsigned QUEUE_DEPTH  = 8
) (
    input  logic             clk,
    input  logic             rst,
    mem_responder_if.slave   bus,
    input  logic             stall_in,
    output logic [OUT_W-1:0] outstanding,
    output logic             error
);

    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned WIDX_W = ADDR_W - OFFS_W;
    localparam int unsigned STAGES = READ_LATENCY - 1;
    localparam int unsigned CNT_W  = $clog2(QUEUE_DEPTH) + 1;

    MEM_REQ_PACKET     req_c;
    MEM_RESP_PACKET    resp_q;
    logic [WIDX_W-1:0] widx_c;
    logic [IDX_W-1:0]  idx_c;
    logic              misaligned_c;
    logic              out_of_range_c;
    logic              bad_addr_c;
    logic              accept_c;
    logic              both_c;
    logic              wr_take_c;
    logic              rd_take_c;
    logic              pop_c;
    logic              ready_q;
    logic              error_q;
    logic              error_d;
    logic [OUT_W-1:0]  outstanding_q;
    logic [OUT_W-1:0]  outstanding_d;

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [STAGES-1:0] pipe_vld_q;
    logic [DATA_W-1:0] pipe_data_q [STAGES];

    logic [DATA_W-1:0] fifo_dout_c;
    logic              fifo_full_c;
    logic              fifo_empty_c;
    logic [CNT_W-1:0]  fifo_count_c;
    logic              unused_fifo_c;

    assign req_c.addr  = bus.mem_addr;
    assign req_c.wdata = bus.mem_write_data;
    assign req_c.rd    = bus.mem_read;
    assign req_c.wr    = bus.mem_write;

    // Address decode: word index plus alignment and range checks.
    assign widx_c         = req_c.addr[ADDR_W-1:OFFS_W];
    assign idx_c          = widx_c[IDX_W-1:0];
    assign misaligned_c   = (req_c.addr[OFFS_W-1:0] != '0);
    assign out_of_range_c = (widx_c >= WIDX_W'(DEPTH_WORDS));
    assign bad_addr_c     = misaligned_c | out_of_range_c;

    // Read+write together keeps the write and drops the read; bad-address reads still
    // produce a zero response so the in-order stream stays aligned with requests.
    assign accept_c  = (req_c.rd | req_c.wr) & ready_q;
    assign both_c    = req_c.rd & req_c.wr;
    assign wr_take_c = accept_c & req_c.wr & ~bad_addr_c;
    assign rd_take_c = accept_c & req_c.rd & ~req_c.wr;
    assign pop_c     = ~fifo_empty_c & ~stall_in;

    assign error_d       = error_q | (accept_c & (both_c | bad_addr_c));
    assign outstanding_d = outstanding_q + OUT_W'(rd_take_c) - OUT_W'(pop_c);

    // SRAM write port.
    always_ff @(posedge clk) begin
        if (wr_take_c) mem_q[idx_c] <= req_c.wdata;
    end

    // Latency pipeline data path; stage 0 captures the array read at accept.
    always_ff @(posedge clk) begin
        pipe_data_q[0] <= bad_addr_c ? '0 : mem_q[idx_c];
        for (int i = 1; i < int'(STAGES); i++) begin
            pipe_data_q[i] <= pipe_data_q[i-1];
        end
    end

    // Latency pipeline valids.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q[0] <= rd_take_c;
            for (int i = 1; i < int'(STAGES); i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
            end
        end
    end

    // Counter covers pipeline + FIFO, so gating ready on it keeps the FIFO from overflowing.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_q <= '0;
            ready_q       <= 1'b0;
            error_q       <= 1'b0;
            resp_q        <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            ready_q       <= (outstanding_d < OUT_W'(QUEUE_DEPTH));
            error_q       <= error_d;
            resp_q.valid  <= pop_c;
            if (pop_c) resp_q.rdata <= fifo_dout_c;
        end
    end

    mem_resp_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pipe_vld_q[STAGES-1]),
        .pop_i   (pop_c),
        .din_i   (pipe_data_q[STAGES-1]),
        .dout_o  (fifo_dout_c),
        .full_o  (fifo_full_c),
        .empty_o (fifo_empty_c),
        .count_o (fifo_count_c)
    );

    assign unused_fifo_c = ^{fifo_full_c, fifo_count_c};

    assign bus.mem_ready     = ready_q;
    assign bus.mem_read_data = resp_q.rdata;
    assign bus.mem_valid     = resp_q.valid;
    assign outstanding       = outstanding_q;
    assign error             = error_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder.
module tb_mem_responder;
    import mem_responder_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall_in;
    logic [OUT_W-1:0] outstanding;
    logic             error;

    mem_responder_if bus();

    mem_responder dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .stall_in    (stall_in),
        .outstanding (outstanding),
        .error       (error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int unsigned cyc = 0;
    logic [DATA_W-1:0] got_data [$];
    int unsigned       got_cyc  [$];

    localparam logic [DATA_W-1:0] PAT_A5 = {MEM_BANDWIDTH{8'hA5}};
    localparam logic [DATA_W-1:0] PAT_3C = {MEM_BANDWIDTH{8'h3C}};
    localparam logic [DATA_W-1:0] PAT_FF = {MEM_BANDWIDTH{8'hFF}};
    localparam logic [DATA_W-1:0] PAT_5A = DATA_W'(32'h5A5A_1234);

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor, sampled 2ns after each rising edge.
    always @(posedge clk) begin
        #2;
        if (bus.mem_valid === 1'b1) begin
            got_data.push_back(bus.mem_read_data);
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    // Drive one request (called at a negedge); returns the cycle index of the accept edge.
    task automatic issue(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, output int unsigned acc);
        int n = 0;
        bus.mem_read = rd;
        bus.mem_write = wr;
        bus.mem_addr = a;
        bus.mem_write_data = d;
        while (bus.mem_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout addr=%0h got ready=%b want 1", a, bus.mem_ready);
        end
        acc = cyc + 1;
        @(negedge clk);
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic wait_resp(input int n, input int budget);
        int k = 0;
        while (got_data.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.mem_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b want=0", bus.mem_valid); end
        checks++;
        if (bus.mem_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b want=0", bus.mem_ready); end
        checks++;
        if (outstanding !== 4'd0) begin failures++; $display("FAIL rst_outstanding got=%0d want=0", outstanding); end
        checks++;
        if (error !== 1'b0) begin failures++; $display("FAIL rst_error got=%b want=0", error); end
        checks++;
        if (bus.mem_read_data !== '0) begin failures++; $display("FAIL rst_rdata got=%0h want=0", bus.mem_read_data); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_after got=%b want=1", bus.mem_ready); end
    endtask

    task automatic test_write_read();
        int unsigned acc;
        got_data.delete(); got_cyc.delete();
        issue(1'b0, 1'b1, 32'h40, PAT_A5, acc);
        issue(1'b1, 1'b0, 32'h40, '0, acc);
        checks++;
        if (outstanding !== 4'd1) begin failures++; $display("FAIL wr_rd_outst_pending got=%0d want=1", outstanding); end
        wait_resp(1, 20);
        checks++;
        if (got_data.size() != 1) begin failures++; $display("FAIL wr_rd_count got=%0d want=1", got_data.size()); end
        else begin
            checks++;
            if (got_data[0] !== PAT_A5) begin failures++; $display("FAIL wr_rd_data got=%0h want=%0h", got_data[0], PAT_A5); end
            checks++;
            if (got_cyc[0] - acc != 4) begin failures++; $display("FAIL wr_rd_latency got=%0d want=4", got_cyc[0] - acc); end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (outstanding !== 4'd0 || error !== 1'b0) begin
            failures++; $display("FAIL wr_rd_idle got outst=%0d err=%b want 0/0", outstanding, error);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned acc;
        int unsigned first_acc;
        for (int k = 0; k < 8; k++) issue(1'b0, 1'b1, ADDR_W'(64 * k), DATA_W'(k), acc);
        got_data.delete(); got_cyc.delete();
        for (int k = 0; k < 8; k++) begin
            issue(1'b1, 1'b0, ADDR_W'(64 * k), '0, acc);
            if (k == 0) first_acc = acc;
        end
        wait_resp(8, 40);
        checks++;
        if (got_data.size() != 8) begin failures++; $display("FAIL b2b_count got=%0d want=8", got_data.size()); end
        else begin
            checks++;
            if (got_cyc[0] - first_acc != 4) begin failures++; $display("FAIL b2b_latency got=%0d want=4", got_cyc[0] - first_acc); end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_data[i] !== DATA_W'(i)) begin failures++; $display("FAIL b2b_data[%0d] got=%0h want=%0h", i, got_data[i], i); end
                if (i > 0) begin
                    checks++;
                    if (got_cyc[i] - got_cyc[i-1] != 1) begin failures++; $display("FAIL b2b_gap[%0d] got=%0d want=1", i, got_cyc[i] - got_cyc[i-1]); end
                end
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.mem_valid !== 1'b0 || bus.mem_read_data !== DATA_W'(7)) begin
            failures++; $display("FAIL b2b_hold got valid=%b data=%0h want 0/7", bus.mem_valid, bus.mem_read_data);
        end
    endtask

    task automatic test_stall();
        int unsigned acc;
        for (int k = 8; k < 12; k++) issue(1'b0, 1'b1, ADDR_W'(64 * k), DATA_W'(256 + k), acc);
        got_data.delete(); got_cyc.delete();
        stall_in = 1'b1;
        for (int k = 0; k < 8; k++) issue(1'b1, 1'b0, ADDR_W'(64 * k), '0, acc);
        bus.mem_read = 1'b1;
        bus.mem_addr = ADDR_W'(64 * 8);
        repeat (12) @(negedge clk);
        checks++;
        if (bus.mem_ready !== 1'b0) begin failures++; $display("FAIL stall_ready got=%b want=0", bus.mem_ready); end
        checks++;
        if (outstanding !== 4'd8) begin failures++; $display("FAIL stall_outstanding got=%0d want=8", outstanding); end
        checks++;
        if (got_data.size() != 0) begin failures++; $display("FAIL stall_no_valid got=%0d want=0", got_data.size()); end
        stall_in = 1'b0;
        for (int k = 8; k < 12; k++) issue(1'b1, 1'b0, ADDR_W'(64 * k), '0, acc);
        wait_resp(12, 60);
        checks++;
        if (got_data.size() != 12) begin failures++; $display("FAIL stall_count got=%0d want=12", got_data.size()); end
        else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (got_data[i] !== ((i < 8) ? DATA_W'(i) : DATA_W'(256 + i))) begin
                    failures++; $display("FAIL stall_data[%0d] got=%0h", i, got_data[i]);
                end
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (outstanding !== 4'd0 || bus.mem_ready !== 1'b1) begin
            failures++; $display("FAIL stall_drain got outst=%0d ready=%b want 0/1", outstanding, bus.mem_ready);
        end
    endtask

    task automatic test_rw_conflict();
        int unsigned acc;
        got_data.delete(); got_cyc.delete();
        issue(1'b1, 1'b1, 32'h80, PAT_3C, acc);
        checks++;
        if (error !== 1'b1) begin failures++; $display("FAIL rw_error got=%b want=1", error); end
        checks++;
        if (outstanding !== 4'd0) begin failures++; $display("FAIL rw_outstanding got=%0d want=0", outstanding); end
        repeat (10) @(negedge clk);
        checks++;
        if (got_data.size() != 0) begin failures++; $display("FAIL rw_no_valid got=%0d want=0", got_data.size()); end
        issue(1'b1, 1'b0, 32'h80, '0, acc);
        wait_resp(1, 20);
        checks++;
        if (got_data.size() != 1 || got_data[0] !== PAT_3C) begin
            failures++; $display("FAIL rw_write_kept got=%0h want=%0h", (got_data.size() > 0) ? got_data[0] : '0, PAT_3C);
        end
    endtask

    task automatic test_bad_addr();
        int unsigned acc;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (error !== 1'b0) begin failures++; $display("FAIL bad_err_cleared got=%b want=0", error); end
        issue(1'b0, 1'b1, 32'h3FFC0, PAT_5A, acc);
        checks++;
        if (error !== 1'b0) begin failures++; $display("FAIL bad_last_word_ok got=%b want=0", error); end
        got_data.delete(); got_cyc.delete();
        issue(1'b1, 1'b0, 32'h41, '0, acc);
        checks++;
        if (error !== 1'b1) begin failures++; $display("FAIL bad_misaligned_err got=%b want=1", error); end
        issue(1'b1, 1'b0, 32'h40000, '0, acc);
        issue(1'b1, 1'b0, 32'h3FFC0, '0, acc);
        issue(1'b1, 1'b0, 32'h80, '0, acc);
        wait_resp(4, 30);
        checks++;
        if (got_data.size() != 4) begin failures++; $display("FAIL bad_count got=%0d want=4", got_data.size()); end
        else begin
            checks++;
            if (got_data[0] !== '0) begin failures++; $display("FAIL bad_misaligned_data got=%0h want=0", got_data[0]); end
            checks++;
            if (got_data[1] !== '0) begin failures++; $display("FAIL bad_range_data got=%0h want=0", got_data[1]); end
            checks++;
            if (got_data[2] !== PAT_5A) begin failures++; $display("FAIL bad_last_word_data got=%0h want=%0h", got_data[2], PAT_5A); end
            checks++;
            if (got_data[3] !== PAT_3C) begin failures++; $display("FAIL bad_order_data got=%0h want=%0h", got_data[3], PAT_3C); end
        end
        got_data.delete(); got_cyc.delete();
        issue(1'b0, 1'b1, 32'h81, PAT_FF, acc);
        issue(1'b1, 1'b0, 32'h80, '0, acc);
        wait_resp(1, 20);
        checks++;
        if (got_data.size() != 1 || got_data[0] !== PAT_3C) begin
            failures++; $display("FAIL bad_write_dropped got=%0h want=%0h", (got_data.size() > 0) ? got_data[0] : '0, PAT_3C);
        end
    endtask

    task automatic test_reset_midburst();
        int unsigned acc;
        got_data.delete(); got_cyc.delete();
        for (int k = 0; k < 3; k++) issue(1'b1, 1'b0, 32'h80, '0, acc);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.mem_ready !== 1'b0 || outstanding !== 4'd0) begin
            failures++; $display("FAIL mid_rst_state got ready=%b outst=%0d want 0/0", bus.mem_ready, outstanding);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_ready !== 1'b1) begin failures++; $display("FAIL mid_ready_after got=%b want=1", bus.mem_ready); end
        repeat (15) @(negedge clk);
        checks++;
        if (got_data.size() != 0) begin failures++; $display("FAIL mid_no_valid got=%0d want=0", got_data.size()); end
        checks++;
        if (outstanding !== 4'd0 || error !== 1'b0) begin
            failures++; $display("FAIL mid_idle got outst=%0d err=%b want 0/0", outstanding, error);
        end
        issue(1'b1, 1'b0, 32'h80, '0, acc);
        issue(1'b1, 1'b0, 32'h3FFC0, '0, acc);
        wait_resp(2, 20);
        checks++;
        if (got_data.size() != 2) begin failures++; $display("FAIL mid_after_count got=%0d want=2", got_data.size()); end
        else begin
            checks++;
            if (got_data[0] !== PAT_3C || got_data[1] !== PAT_5A) begin
                failures++; $display("FAIL mid_array_kept got=%0h,%0h want=%0h,%0h", got_data[0], got_data[1], PAT_3C, PAT_5A);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        stall_in = 1'b0;
        bus.mem_addr = '0;
        bus.mem_write_data = '0;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_write_read();
        test_back_to_back();
        test_stall();
        test_rw_conflict();
        test_bad_addr();
        test_reset_midburst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
